// File: rtl/source_rport_arbiter_pkg.sv
// Shared sizing, state encoding and operand-index helpers for the source-stage
// ARF read-port arbiter.
package source_arb_pkg;

    localparam int NSLOT  = 8;
    localparam int NPORTS = 6;
    localparam int AW     = 5;
    localparam int DW     = 64;

    localparam int NOPS = 2 * NSLOT;
    localparam int CW   = $clog2(NOPS + 1);

    // Slot base offsets within a bundle: ALU0-3, MEM0-1, BR0, MUL0
    localparam int SLOT_ALU = 0;
    localparam int SLOT_MEM = 4;
    localparam int SLOT_BR  = 6;
    localparam int SLOT_MUL = 7;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_COLLECT = 2'd1;
    localparam logic [1:0] ST_DONE    = 2'd2;

    typedef enum logic [1:0] {
        IDLE    = ST_IDLE,
        COLLECT = ST_COLLECT,
        DONE    = ST_DONE
    } arb_state_t;

    // Flat operand index: two operands per slot, op is 1 or 2
    function automatic int op_idx(input int slot, input int op);
        return 2 * slot + op - 1;
    endfunction

endpackage

// File: rtl/source_rport_arbiter_if.sv
// Issue-side, ARF-side and execute-side signals of the read-port arbiter.
interface source_rport_arbiter_if;
    import source_arb_pkg::*;

    logic                   flush;
    logic                   in_valid;
    logic                   in_ready;
    logic [NSLOT-1:0]       in_slot_valid;
    logic [NSLOT*AW-1:0]    in_src1;
    logic [NSLOT*AW-1:0]    in_src2;
    logic [NSLOT-1:0]       in_fwd1;
    logic [NSLOT-1:0]       in_fwd2;
    logic [NPORTS*AW-1:0]   arf_ra;
    logic [NPORTS*DW-1:0]   arf_rd;
    logic                   out_valid;
    logic                   out_ready;
    logic [NSLOT*DW-1:0]    out_d1;
    logic [NSLOT*DW-1:0]    out_d2;
    logic                   busy;
    logic [31:0]            stall_cnt;

    modport master (
        output flush, in_valid, in_slot_valid, in_src1, in_src2, in_fwd1, in_fwd2,
        output arf_rd, out_ready,
        input  in_ready, arf_ra, out_valid, out_d1, out_d2, busy, stall_cnt
    );

    modport slave (
        input  flush, in_valid, in_slot_valid, in_src1, in_src2, in_fwd1, in_fwd2,
        input  arf_rd, out_ready,
        output in_ready, arf_ra, out_valid, out_d1, out_d2, busy, stall_cnt
    );

endinterface

// File: rtl/source_rport_arbiter_rport_alloc.sv
// Fixed-priority selector: the p-th set bit of the pending mask (from index 0
// upward) is routed to read port p, for p < NPORTS.
module rport_alloc
    import source_arb_pkg::*;
(
    input  logic [NOPS-1:0]               pend_i,
    output logic [NPORTS-1:0][NOPS-1:0]   sel_o,
    output logic [NPORTS-1:0]             port_vld_o,
    output logic [NOPS-1:0]               grant_o
);

    // rank[k] = number of pending bits strictly below k
    logic [NOPS-1:0][CW-1:0] rank;

    always_comb begin
        logic [CW-1:0] cnt;
        cnt  = '0;
        rank = '0;
        for (int k = 0; k < NOPS; k++) begin
            rank[k] = cnt;
            cnt     = cnt + {{(CW-1){1'b0}}, pend_i[k]};
        end
    end

    genvar gi, gj;
    generate
        for (gi = 0; gi < NOPS; gi++) begin : g_grant
            assign grant_o[gi] = pend_i[gi] && (rank[gi] < CW'(NPORTS));
        end

        for (gj = 0; gj < NPORTS; gj++) begin : g_port
            for (gi = 0; gi < NOPS; gi++) begin : g_op
                assign sel_o[gj][gi] = pend_i[gi] && (rank[gi] == CW'(gj));
            end
            assign port_vld_o[gj] = |sel_o[gj];
        end
    endgenerate

endmodule

// File: rtl/source_rport_arbiter.sv
// Collects the ARF-sourced operands of one issued bundle over as many cycles as
// the NPORTS read ports require, then holds the assembled bundle for execute.
module source_rport_arbiter
    import source_arb_pkg::*;
(
    input  logic                  clk,
    input  logic                  resetn,
    source_rport_arbiter_if.slave bus
);

    logic [1:0]                   state_q, state_d;
    logic [NOPS-1:0]              pend_q, pend_d;
    logic [NOPS-1:0][AW-1:0]      src_q;
    logic [NOPS-1:0][DW-1:0]      opd_q;
    logic [31:0]                  stall_q;

    logic [NOPS-1:0][AW-1:0]      src_in;
    logic [NOPS-1:0][AW-1:0]      src_cur;
    logic [NOPS-1:0]              req;
    logic [NOPS-1:0]              alloc_mask;
    logic [NOPS-1:0]              grant;
    logic [NOPS-1:0][DW-1:0]      rd_op;
    logic [NPORTS-1:0][NOPS-1:0]  sel;
    logic [NPORTS-1:0]            port_vld;
    logic                         in_ready;
    logic                         accept;
    logic                         collecting;

    genvar gi;
    generate
        for (gi = 0; gi < NSLOT; gi++) begin : g_slot
            assign src_in[op_idx(gi, 1)] = bus.in_src1[gi*AW +: AW];
            assign src_in[op_idx(gi, 2)] = bus.in_src2[gi*AW +: AW];
            assign req[op_idx(gi, 1)] = bus.in_slot_valid[gi] && !bus.in_fwd1[gi]
                                        && (src_in[op_idx(gi, 1)] != '0);
            assign req[op_idx(gi, 2)] = bus.in_slot_valid[gi] && !bus.in_fwd2[gi]
                                        && (src_in[op_idx(gi, 2)] != '0);
            assign bus.out_d1[gi*DW +: DW] = opd_q[op_idx(gi, 1)];
            assign bus.out_d2[gi*DW +: DW] = opd_q[op_idx(gi, 2)];
        end
    endgenerate

    // A flush or reset blocks acceptance; DONE may hand over and accept in one cycle
    assign in_ready   = resetn && !bus.flush &&
                        ((state_q == ST_IDLE) || ((state_q == ST_DONE) && bus.out_ready));
    assign accept     = bus.in_valid && in_ready;
    assign collecting = (state_q == ST_COLLECT) && !bus.flush;
    assign alloc_mask = accept ? req : (collecting ? pend_q : '0);
    assign src_cur    = (state_q == ST_COLLECT) ? src_q : src_in;

    rport_alloc u_alloc (
        .pend_i     (alloc_mask),
        .sel_o      (sel),
        .port_vld_o (port_vld),
        .grant_o    (grant)
    );

    // Address mux out to the ARF and data mux back to operand order
    always_comb begin
        bus.arf_ra = '0;
        rd_op      = '0;
        for (int p = 0; p < NPORTS; p++) begin
            for (int k = 0; k < NOPS; k++) begin
                if (port_vld[p] && sel[p][k]) begin
                    bus.arf_ra[p*AW +: AW] = bus.arf_ra[p*AW +: AW] | src_cur[k];
                    rd_op[k]               = rd_op[k] | bus.arf_rd[p*DW +: DW];
                end
            end
        end
    end

    always_comb begin
        state_d = state_q;
        pend_d  = pend_q;
        if (bus.flush) begin
            state_d = ST_IDLE;
            pend_d  = '0;
        end else if (accept) begin
            pend_d  = req & ~grant;
            state_d = (pend_d != '0) ? ST_COLLECT : ST_DONE;
        end else begin
            case (state_q)
                ST_COLLECT: begin
                    pend_d = pend_q & ~grant;
                    if (pend_d == '0) begin
                        state_d = ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (bus.out_ready) begin
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
            pend_q  <= '0;
            stall_q <= '0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            if ((state_q == ST_COLLECT) && (stall_q != 32'hFFFF_FFFF)) begin
                stall_q <= stall_q + 32'd1;
            end
        end
    end

    // Unrequested operands are cleared at acceptance so no stale data survives
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            src_q <= '0;
            opd_q <= '0;
        end else begin
            for (int k = 0; k < NOPS; k++) begin
                if (accept) begin
                    src_q[k] <= src_in[k];
                    opd_q[k] <= grant[k] ? rd_op[k] : '0;
                end else if (grant[k]) begin
                    opd_q[k] <= rd_op[k];
                end
            end
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = (state_q == ST_DONE);
    assign bus.busy      = (state_q != ST_IDLE);
    assign bus.stall_cnt = stall_q;

endmodule

// File: doc/source_rport_arbiter.md
Name: source_rport_arbiter

Overview:
- Shares NPORTS physical architectural-register-file (ARF) read ports among the NSLOT issue slots of the source stage.
- Each slot needs up to two operands: 4 ALU, 2 MEM, 1 branch and 1 mult slot, giving 16 potential reads per bundle.
- Accepts one issued bundle and reads all ARF-sourced operands over one or more cycles, at most NPORTS per cycle.
- Presents the assembled operand bundle to the execute register, back-pressuring issue while collecting.

Parameters:
- NSLOT, 8: issue slots per bundle. Slot order is ALU0-3, MEM0-1, BR0, MUL0.
- NPORTS, 6: physical ARF read ports. Legal range is 1..2*NSLOT.
- AW, 5: architectural register index width.
- DW, 64: data width.

Ports:
- clk  in  1  clock
- resetn  in  1  asynchronous active-low reset
- flush  in  1  synchronous pipeline flush
- in_valid  in  1  bundle offered by issue
- in_ready  out  1  bundle accepted when in_valid&in_ready
- in_slot_valid  in  NSLOT  per-slot valid
- in_src1, in_src2  in  NSLOT*AW  operand arch indices
- in_fwd1, in_fwd2  in  NSLOT  operand taken from PRF/forwarding; no ARF read needed
- arf_ra  out  NPORTS*AW  ARF read addresses. The ARF is read combinationally, same cycle.
- arf_rd  in  NPORTS*DW  ARF read data
- out_valid  out  1  assembled bundle valid
- out_ready  in  1  execute register accepts
- out_d1, out_d2  out  NSLOT*DW  ARF operand values
- busy  out  1  state != IDLE
- stall_cnt  out  32  cycles spent in COLLECT, saturating

Behaviour:
- Operand index: k = 2*slot + (op-1), 0..2*NSLOT-1.
- req[k] = slot_valid & !fwd & (src != 0).
- src==0 operands hold 0 with no port used. Forwarded and invalid operands hold 0.
- Port allocation, each cycle a bundle is presented or pending:
  - Scan the pending mask from index 0 upward, fixed priority.
  - The p-th set bit gets port p, arf_ra[p] = its src, p < NPORTS.
  - Unused ports drive arf_ra = 0.
  - arf_rd[p] is captured into the operand holding register at the clock edge.
- States: IDLE, COLLECT, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid, latch the bundle's src fields and pending = req, then grant the first batch in the same cycle.
  - If popcount(req) <= NPORTS, go to DONE. Otherwise go to COLLECT with granted bits cleared.
  - If req==0, go directly to DONE with all-zero data.
- COLLECT:
  - in_ready=0. Grant up to NPORTS pending each cycle and clear them.
  - Go to DONE on the cycle pending becomes empty.
  - stall_cnt += 1 per cycle, saturating at 2^32-1.
- DONE:
  - out_valid=1. Outputs hold stable until out_ready.
  - in_ready = out_ready. Accept-and-grant of a new bundle behaves as in IDLE on the handshake cycle.
  - out_ready without in_valid returns to IDLE.
- Latency:
  - A bundle needing n ARF reads reaches out_valid ceil(max(n,1)/NPORTS) cycles after acceptance.
  - n=0 takes 1 cycle.
- Value semantics:
  - Each operand takes the ARF value on its own grant cycle.
  - Commit must not overwrite an arch reg read by an in-flight bundle. Issue guarantees this; the arbiter does not check it.
- flush, highest priority:
  - Next state IDLE, pending cleared, out_valid=0 next cycle.
  - A bundle offered in the flush cycle is not accepted: in_ready=0 during flush.
  - stall_cnt is not cleared.
- Reset, async, resetn=0:
  - state=IDLE, pending=0, holding regs=0, out_valid=0, in_ready=1 after release.
  - stall_cnt=0, arf_ra=0.
  - Mid-COLLECT reset abandons the bundle.
- Holding registers for unrequested operands are written 0 at acceptance, never stale.

Decomposition:
- Shared package source_arb_pkg:
  - NSLOT, NPORTS, AW, DW.
  - State enum arb_state_t {IDLE, COLLECT, DONE}.
  - Operand-index helper constants: slot base offsets ALU=0, MEM=4, BR=6, MUL=7.
- One sub-module, rport_alloc:
  - Combinational first-NPORTS-set-bits selector.
  - Input: pending mask. Outputs: per-port one-hot select, per-port valid, granted mask.
  - The main block holds the FSM, holding registers, handshake and counter.

Test Plan:
- NPORTS=6, all 8 slots valid, 16 nonzero non-forwarded srcs:
  - Accept at t0. Grants of 6, 6 and 4 reads over t0-t2; out_valid at t3.
  - in_ready=0 at t1-t2; stall_cnt=2.
- Bundle with only ALU0 src1=x5 and ALU0 src2=x0, ARF x5=0xDEAD:
  - arf_ra[0]=5, other ports 0.
  - out_valid next cycle; out_d1[0]=0xDEAD, out_d2[0]=0.
- All operands fwd=1: no ARF ports used, out_valid after 1 cycle, all data 0, stall_cnt unchanged.
- DONE with out_ready=0 for 3 cycles: outputs stable, in_ready=0. Then out_ready=1 with in_valid=1: the new bundle is accepted in the same cycle.
- flush during the second COLLECT cycle: out_valid stays 0, state IDLE next cycle, in_ready=1, no output ever produced for that bundle.
- resetn asserted mid-COLLECT: outputs immediately 0 and stall_cnt=0. After release, a 1-read bundle completes in 1 cycle.
